rec_f32_to_f32_arbiter: RTL

//  Shares one combinational recF32->F32 converter among NUM_REQ requesters using round-robin arbitration.
//  - Each accepted request has its 33-bit recoded operand converted to 32-bit IEEE.
//  - The result is held in a 1-entry output slot with valid/ready handshake, tagged with the source index.
//  - The same converter's encoding checks (zero, exponent, subnormal, NaN) produce a per-result malformed flag.
//  - A saturating counter tallies accepted malformed operands.
//  - Sits between the FPU issue ports and the store/move-to-integer path.

---
 rtl/rec_f32_to_f32_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rec_f32_to_f32_arbiter.sv
// Round-robin arbiter in front of a single recoded-F32 to IEEE-F32 converter.
// One accepted request per cycle is converted and parked in a one-entry
// output slot (valid/ready), tagged with its source index and a malformed
// flag derived from the recoded-format encoding checks. A saturating counter
// tallies accepted malformed operands.
module rec_f32_to_f32_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     io_req_valid,
    output logic [NUM_REQ-1:0]     io_req_ready,
    input  logic [33*NUM_REQ-1:0]  io_req_bits,
    output logic                   io_resp_valid,
    input  logic                   io_resp_ready,
    output logic [31:0]            io_resp_bits,
    output logic [SRC_W-1:0]       io_resp_src,
    output logic                   io_resp_malformed,
    input  logic                   io_clearCount,
    output logic [CNT_W-1:0]       io_badCount
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state_reg;
    slot_state_t      state_next;
    logic [SRC_W-1:0] rr_ptr_reg;
    logic [31:0]      slot_bits_reg;
    logic [SRC_W-1:0] slot_src_reg;
    logic             slot_mal_reg;
    logic [CNT_W-1:0] bad_count_reg;

    logic [32:0]      req_op [NUM_REQ];
    logic             grant_found;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] rr_ptr_next;
    logic             can_accept;
    logic             fire;
    logic [32:0]      sel_op;
    logic [31:0]      conv_bits;
    logic             conv_mal;

    // Unpack the flat operand bus and drive the one-hot grant per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_op[gi]       = io_req_bits[33*gi +: 33];
            assign io_req_ready[gi] = fire && (grant_idx == SRC_W'(gi));
        end
    endgenerate

    // Circular search for the first valid requester starting at rr_ptr.
    always_comb begin
        logic [SRC_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(NUM_REQ)) begin
                cand = cand - (SRC_W+1)'(NUM_REQ);
            end
            if (!grant_found && io_req_valid[cand[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRC_W-1:0];
            end
        end
    end

    // The slot can take a new result when empty or when it drains this cycle.
    assign can_accept  = (state_reg == EMPTY) || io_resp_ready;
    assign fire        = can_accept && grant_found;
    assign rr_ptr_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign sel_op      = req_op[grant_idx];

    // Recoded-to-IEEE conversion of the granted operand plus encoding checks.
    always_comb begin
        logic        sign;
        logic [8:0]  e;
        logic [2:0]  e3;
        logic [22:0] fract;
        logic        is_zero;
        logic        is_sub;
        logic        is_inf;
        logic        is_nan;
        logic [8:0]  shift_dist;
        logic [22:0] sub_fract;
        logic [7:0]  norm_exp;
        logic [4:0]  tz;

        sign       = sel_op[32];
        e          = sel_op[31:23];
        fract      = sel_op[22:0];
        e3         = e[8:6];
        is_zero    = (e3 == 3'b000);
        is_sub     = !is_zero && (e < 9'h082);
        is_inf     = (e3 == 3'b110);
        is_nan     = (e3 == 3'b111);
        shift_dist = 9'h082 - e;
        sub_fract  = 23'({1'b1, fract} >> shift_dist);
        norm_exp   = 8'(e - 9'h081);

        // Trailing-zero count of the fraction (leading zeros of its reverse).
        tz = 5'd23;
        for (int b = 22; b >= 0; b--) begin
            if (fract[b]) begin
                tz = 5'(b);
            end
        end

        conv_bits = {sign, 31'd0};
        if (is_zero) begin
            conv_bits = {sign, 31'd0};
        end else if (is_sub) begin
            conv_bits = {sign, 8'h00, sub_fract};
        end else if (is_inf) begin
            conv_bits = {sign, 8'hFF, 23'd0};
        end else if (is_nan) begin
            conv_bits = {sign, 8'hFF, fract};
        end else begin
            conv_bits = {sign, norm_exp, fract};
        end

        // A subnormal is well formed only if the bits shifted out are zero.
        conv_mal = (is_zero && (fract != 23'd0))
                 || (!is_zero && (e < 9'h06B))
                 || (is_sub && (shift_dist > {4'd0, tz}))
                 || (is_nan && (fract == 23'd0));
    end

    // Slot next-state: fill on accept, drain on consumer ready without refill.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (fire) state_next = FULL;
            FULL:  if (io_resp_ready && !fire) state_next = EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Slot payload and round-robin pointer advance on every accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg    <= '0;
            slot_bits_reg <= '0;
            slot_src_reg  <= '0;
            slot_mal_reg  <= 1'b0;
        end else if (fire) begin
            rr_ptr_reg    <= rr_ptr_next;
            slot_bits_reg <= conv_bits;
            slot_src_reg  <= grant_idx;
            slot_mal_reg  <= conv_mal;
        end
    end

    // Saturating malformed-operand counter; clear takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bad_count_reg <= '0;
        end else if (io_clearCount) begin
            bad_count_reg <= '0;
        end else if (fire && conv_mal && (bad_count_reg != {CNT_W{1'b1}})) begin
            bad_count_reg <= bad_count_reg + 1'b1;
        end
    end

    assign io_resp_valid     = (state_reg == FULL);
    assign io_resp_bits      = slot_bits_reg;
    assign io_resp_src       = slot_src_reg;
    assign io_resp_malformed = slot_mal_reg;
    assign io_badCount       = bad_count_reg;

endmodule
